// File: rtl/ack_window_if.sv
// Handshake bundle for the ACK history window: store requests from the ACK
// timer, ACK2 lookups, and the lookup response.
interface ack_window_if;
   logic        store_valid_i;
   logic        store_ready_o;
   logic [31:0] store_ackseq_i;
   logic [31:0] store_ackno_i;
   logic        ack2_valid_i;
   logic        ack2_ready_o;
   logic [31:0] ack2_seq_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic        rsp_found_o;
   logic [31:0] rsp_ackno_o;
   logic [31:0] rsp_rtt_o;

   // The window itself
   modport slave (
      input  store_valid_i, store_ackseq_i, store_ackno_i,
      input  ack2_valid_i, ack2_seq_i, rsp_ready_i,
      output store_ready_o, ack2_ready_o,
      output rsp_valid_o, rsp_found_o, rsp_ackno_o, rsp_rtt_o
   );

   // The ACK timer / ACK2 parser / RTT consumer side
   modport master (
      output store_valid_i, store_ackseq_i, store_ackno_i,
      output ack2_valid_i, ack2_seq_i, rsp_ready_i,
      input  store_ready_o, ack2_ready_o,
      input  rsp_valid_o, rsp_found_o, rsp_ackno_o, rsp_rtt_o
   );
endinterface

// File: rtl/ack_window.sv
// Circular history of sent ACKs (seq, ackno, send time). An ACK2 scans from the
// oldest entry, returns ackno + RTT of the first match, and retires it and older.
module ack_window #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          core_clk,
   input  logic          core_rst_n,
   input  logic [63:0]   currtime,
   ack_window_if.slave   bus,
   output logic [AW:0]   win_cnt_o
);

   typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

   state_t        state;
   logic [31:0]   seq_mem   [DEPTH];
   logic [31:0]   ackno_mem [DEPTH];
   logic [63:0]   time_mem  [DEPTH];
   logic [AW-1:0] head, tail, ptr;
   logic [AW:0]   count, scanned;
   logic [31:0]   seq_q;
   logic          rsp_valid, rsp_found;
   logic [31:0]   rsp_ackno, rsp_rtt;
   logic          store_fire, ack2_fire;
   logic [63:0]   rtt_full;

   // Store always wins the IDLE slot; ACK2 waits a cycle if both arrive.
   assign bus.store_ready_o = (state == IDLE);
   assign bus.ack2_ready_o  = (state == IDLE) && !bus.store_valid_i;
   assign store_fire        = bus.store_valid_i && bus.store_ready_o;
   assign ack2_fire         = bus.ack2_valid_i && bus.ack2_ready_o;
   assign rtt_full          = currtime - time_mem[ptr];

   assign bus.rsp_valid_o = rsp_valid;
   assign bus.rsp_found_o = rsp_found;
   assign bus.rsp_ackno_o = rsp_ackno;
   assign bus.rsp_rtt_o   = rsp_rtt;
   assign win_cnt_o       = count;

   always_ff @(posedge core_clk) begin
      if (store_fire) begin
         seq_mem[head]   <= bus.store_ackseq_i;
         ackno_mem[head] <= bus.store_ackno_i;
         time_mem[head]  <= currtime;
      end
   end

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         ptr       <= '0;
         count     <= '0;
         scanned   <= '0;
         seq_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_found <= 1'b0;
         rsp_ackno <= '0;
         rsp_rtt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (store_fire) begin
                  head <= head + AW'(1);
                  // Full window: the oldest entry is overwritten in place.
                  if (count == (AW+1)'(DEPTH)) tail  <= tail + AW'(1);
                  else                          count <= count + (AW+1)'(1);
               end else if (ack2_fire) begin
                  seq_q   <= bus.ack2_seq_i;
                  ptr     <= tail;
                  scanned <= '0;
                  state   <= SEARCH;
               end
            end
            SEARCH: begin
               if (scanned == count) begin
                  rsp_found <= 1'b0;
                  rsp_ackno <= '0;
                  rsp_rtt   <= '0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (seq_mem[ptr] == seq_q) begin
                  rsp_found <= 1'b1;
                  rsp_ackno <= ackno_mem[ptr];
                  rsp_rtt   <= (rtt_full[63:32] != '0) ? 32'hFFFF_FFFF : rtt_full[31:0];
                  rsp_valid <= 1'b1;
                  // Retire the match together with everything older than it.
                  tail      <= ptr + AW'(1);
                  count     <= count - scanned - (AW+1)'(1);
                  state     <= RESP;
               end else begin
                  ptr     <= ptr + AW'(1);
                  scanned <= scanned + (AW+1)'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
